// File: rtl/alu_cmd_sequencer_if.sv
// alu_cmd_sequencer_if: command and response valid/ready channels of the ALU command sequencer
interface alu_cmd_sequencer_if;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [2:0] cmd_opcode;
   logic [7:0] cmd_src1;
   logic [7:0] cmd_src2;
   logic       rsp_valid;
   logic       rsp_ready;
   logic [7:0] rsp_result;
   logic       rsp_zero;
   logic       rsp_overflow;
   modport master (
      output cmd_valid, cmd_opcode, cmd_src1, cmd_src2, rsp_ready,
      input  cmd_ready, rsp_valid, rsp_result, rsp_zero, rsp_overflow
   );
   modport slave (
      input  cmd_valid, cmd_opcode, cmd_src1, cmd_src2, rsp_ready,
      output cmd_ready, rsp_valid, rsp_result, rsp_zero, rsp_overflow
   );
endinterface

// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: decodes commands onto the ripple ALU, waits for it to settle, returns the captured result
module alu_cmd_sequencer #(
   parameter int SETTLE_CYCLES = 1,
   parameter int CNT_W         = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   alu_cmd_sequencer_if.slave   bus,
   output logic [7:0]           ALU_src1,
   output logic [7:0]           ALU_src2,
   output logic                 Ainvert,
   output logic                 Binvert,
   output logic [1:0]           op,
   input  logic [7:0]           alu_result,
   input  logic                 alu_zero,
   input  logic                 alu_overflow,
   output logic                 ovf_sticky,
   input  logic                 ovf_clr,
   output logic [CNT_W-1:0]     done_cnt
);
   typedef enum logic [1:0] {IDLE, SETTLE, RESP} state_t;
   localparam logic [2:0] OP_AND = 3'd0, OP_OR = 3'd1, OP_ADD = 3'd2, OP_SUB = 3'd3,
                          OP_SLT = 3'd4, OP_NOR = 3'd5, OP_NAND = 3'd6, OP_CMP = 3'd7;
   state_t           state_q, state_d;
   logic [3:0]       cnt_q, cnt_d;
   logic [7:0]       src1_q, src1_d, src2_q, src2_d;
   logic             ainv_q, ainv_d, binv_q, binv_d;
   logic [1:0]       op_q, op_d;
   logic             arith_q, arith_d, cmp_q, cmp_d;
   logic             cmd_ready_q, cmd_ready_d, rsp_valid_q, rsp_valid_d;
   logic [7:0]       rsp_result_q, rsp_result_d;
   logic             rsp_zero_q, rsp_zero_d, rsp_ovf_q, rsp_ovf_d;
   logic             ovf_sticky_q, ovf_sticky_d;
   logic [CNT_W-1:0] done_cnt_q, done_cnt_d;
   logic [2:0]       opc;
   logic             capture;
   assign opc     = bus.cmd_opcode;
   assign capture = state_q == SETTLE && cnt_q == 4'd0;
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      src1_d       = src1_q;
      src2_d       = src2_q;
      ainv_d       = ainv_q;
      binv_d       = binv_q;
      op_d         = op_q;
      arith_d      = arith_q;
      cmp_d        = cmp_q;
      cmd_ready_d  = cmd_ready_q;
      rsp_valid_d  = rsp_valid_q;
      rsp_result_d = rsp_result_q;
      rsp_zero_d   = rsp_zero_q;
      rsp_ovf_d    = rsp_ovf_q;
      done_cnt_d   = done_cnt_q;
      if (state_q == IDLE && bus.cmd_valid) begin
         state_d     = SETTLE;
         cmd_ready_d = 1'b0;
         cnt_d       = 4'(SETTLE_CYCLES - 1);
         src1_d      = bus.cmd_src1;
         src2_d      = bus.cmd_src2;
         ainv_d      = opc == OP_NOR || opc == OP_NAND;
         binv_d      = !(opc == OP_AND || opc == OP_OR || opc == OP_ADD);
         arith_d     = opc == OP_ADD || opc == OP_SUB || opc == OP_CMP;
         cmp_d       = opc == OP_CMP;
         op_d        = opc == OP_SLT ? 2'b11 :
                       (opc == OP_ADD || opc == OP_SUB || opc == OP_CMP) ? 2'b10 :
                       (opc == OP_OR || opc == OP_NAND) ? 2'b01 : 2'b00;
      end
      if (state_q == SETTLE) cnt_d = capture ? cnt_q : cnt_q - 4'd1;
      if (capture) begin
         state_d      = RESP;
         rsp_valid_d  = 1'b1;
         rsp_result_d = cmp_q ? 8'h00 : alu_result;
         rsp_zero_d   = alu_zero;
         rsp_ovf_d    = arith_q & alu_overflow;
      end
      if (state_q == RESP && bus.rsp_ready) begin
         state_d     = IDLE;
         rsp_valid_d = 1'b0;
         cmd_ready_d = 1'b1;
         done_cnt_d  = done_cnt_q + CNT_W'(1);
      end
      // a capture that sets the flag beats a simultaneous clear
      ovf_sticky_d = (capture & arith_q & alu_overflow) | (ovf_sticky_q & ~ovf_clr);
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         cnt_q        <= 4'd0;
         src1_q       <= 8'h00;
         src2_q       <= 8'h00;
         ainv_q       <= 1'b0;
         binv_q       <= 1'b0;
         op_q         <= 2'b00;
         arith_q      <= 1'b0;
         cmp_q        <= 1'b0;
         cmd_ready_q  <= 1'b1;
         rsp_valid_q  <= 1'b0;
         rsp_result_q <= 8'h00;
         rsp_zero_q   <= 1'b0;
         rsp_ovf_q    <= 1'b0;
         ovf_sticky_q <= 1'b0;
         done_cnt_q   <= '0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         src1_q       <= src1_d;
         src2_q       <= src2_d;
         ainv_q       <= ainv_d;
         binv_q       <= binv_d;
         op_q         <= op_d;
         arith_q      <= arith_d;
         cmp_q        <= cmp_d;
         cmd_ready_q  <= cmd_ready_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_result_q <= rsp_result_d;
         rsp_zero_q   <= rsp_zero_d;
         rsp_ovf_q    <= rsp_ovf_d;
         ovf_sticky_q <= ovf_sticky_d;
         done_cnt_q   <= done_cnt_d;
      end
   end
   assign ALU_src1         = src1_q;
   assign ALU_src2         = src2_q;
   assign Ainvert          = ainv_q;
   assign Binvert          = binv_q;
   assign op               = op_q;
   assign bus.cmd_ready    = cmd_ready_q;
   assign bus.rsp_valid    = rsp_valid_q;
   assign bus.rsp_result   = rsp_result_q;
   assign bus.rsp_zero     = rsp_zero_q;
   assign bus.rsp_overflow = rsp_ovf_q;
   assign ovf_sticky       = ovf_sticky_q;
   assign done_cnt         = done_cnt_q;
endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// tb_alu_cmd_sequencer: directed checks of the sequencer against a behavioural 8-bit ripple ALU
module tb_alu_cmd_sequencer;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] alu_src1, alu_src2, alu_result;
   logic       ainvert, binvert, alu_zero, alu_overflow, ovf_sticky, ovf_clr;
   logic [1:0] op, done_cnt;
   logic [7:0] a_eff, b_eff;
   logic [8:0] sum;
   int         n_tests = 0, n_fail = 0, lat;
   alu_cmd_sequencer_if bus ();
   alu_cmd_sequencer #(.SETTLE_CYCLES(1), .CNT_W(2)) dut (
      .clk(clk), .rst(rst), .bus(bus),
      .ALU_src1(alu_src1), .ALU_src2(alu_src2), .Ainvert(ainvert), .Binvert(binvert), .op(op),
      .alu_result(alu_result), .alu_zero(alu_zero), .alu_overflow(alu_overflow),
      .ovf_sticky(ovf_sticky), .ovf_clr(ovf_clr), .done_cnt(done_cnt)
   );
   always #5 clk = ~clk;
   // ripple ALU stand-in: SLT corrects the sign bit with overflow
   assign a_eff        = ainvert ? ~alu_src1 : alu_src1;
   assign b_eff        = binvert ? ~alu_src2 : alu_src2;
   assign sum          = {1'b0, a_eff} + {1'b0, b_eff} + {8'h00, binvert};
   assign alu_overflow = (a_eff[7] == b_eff[7]) && (sum[7] != a_eff[7]);
   assign alu_result   = op == 2'b00 ? (a_eff & b_eff) : op == 2'b01 ? (a_eff | b_eff) :
                         op == 2'b10 ? sum[7:0] : {7'b0, sum[7] ^ alu_overflow};
   assign alu_zero     = alu_result == 8'h00;
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   task automatic issue(input logic [2:0] opc, input logic [7:0] a, input logic [7:0] b, input logic clr);
      @(negedge clk);
      bus.cmd_valid = 1'b1; bus.cmd_opcode = opc; bus.cmd_src1 = a; bus.cmd_src2 = b;
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      ovf_clr = clr;
      lat = 0;
      while (!bus.rsp_valid && lat < 20) begin
         @(negedge clk);
         ovf_clr = 1'b0;
         lat++;
      end
   endtask
   task automatic consume();
      bus.rsp_ready = 1'b1;
      @(negedge clk);
      bus.rsp_ready = 1'b0;
   endtask
   task automatic check_rsp(input string tag, input logic [7:0] r, input logic z, input logic v);
      check({tag, " latency"}, lat, 1);
      check({tag, " result"}, bus.rsp_result, r);
      check({tag, " zero"}, bus.rsp_zero, z);
      check({tag, " ovf"}, bus.rsp_overflow, v);
   endtask
   task automatic check_idle(input string tag);
      check({tag, " cmd_ready"}, bus.cmd_ready, 1);
      check({tag, " rsp_valid"}, bus.rsp_valid, 0);
      check({tag, " rsp_result"}, bus.rsp_result, 0);
      check({tag, " rsp_zero"}, bus.rsp_zero, 0);
      check({tag, " rsp_ovf"}, bus.rsp_overflow, 0);
      check({tag, " sticky"}, ovf_sticky, 0);
      check({tag, " done_cnt"}, done_cnt, 0);
      check({tag, " alu_ctl"}, {alu_src1, alu_src2, ainvert, binvert, op}, 0);
   endtask
   initial begin
      bus.cmd_valid = 1'b0; bus.cmd_opcode = 3'd0; bus.cmd_src1 = 8'h00; bus.cmd_src2 = 8'h00;
      bus.rsp_ready = 1'b0; ovf_clr = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      check_idle("reset");
      issue(3'd2, 8'h7F, 8'h01, 1'b0);
      check("add ctl", {ainvert, binvert, op}, 4'b0010);
      check_rsp("add", 8'h80, 1'b0, 1'b1);
      check("add sticky", ovf_sticky, 1);
      consume();
      check("add done", done_cnt, 1);
      check("add cmd_ready", bus.cmd_ready, 1);
      ovf_clr = 1'b1;
      @(negedge clk);
      ovf_clr = 1'b0;
      check("clr sticky", ovf_sticky, 0);
      issue(3'd3, 8'h05, 8'h05, 1'b0);
      check("sub ctl", {ainvert, binvert, op}, 4'b0110);
      check_rsp("sub", 8'h00, 1'b1, 1'b0);
      consume();
      issue(3'd4, 8'h80, 8'h01, 1'b0);
      check("slt ctl", {ainvert, binvert, op}, 4'b0111);
      check_rsp("slt", 8'h01, 1'b0, 1'b0);
      check("slt sticky", ovf_sticky, 0);
      consume();
      check("slt done", done_cnt, 3);
      issue(3'd7, 8'h80, 8'h01, 1'b1);
      check("cmp ctl", {ainvert, binvert, op}, 4'b0110);
      check_rsp("cmp", 8'h00, 1'b0, 1'b1);
      check("cmp sticky set wins", ovf_sticky, 1);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("stall valid", bus.rsp_valid, 1);
         check("stall rsp", {bus.rsp_result, bus.rsp_zero, bus.rsp_overflow}, {8'h00, 1'b0, 1'b1});
         check("stall cmd_ready", bus.cmd_ready, 0);
         check("stall done", done_cnt, 3);
      end
      consume();
      check("wrap done", done_cnt, 0);
      issue(3'd5, 8'hF0, 8'h0F, 1'b0);
      check("nor ctl", {ainvert, binvert, op}, 4'b1100);
      check_rsp("nor", 8'h00, 1'b1, 1'b0);
      consume();
      issue(3'd0, 8'hF0, 8'h3C, 1'b0);
      check_rsp("and", 8'h30, 1'b0, 1'b0);
      consume();
      issue(3'd1, 8'hF0, 8'h0F, 1'b0);
      check_rsp("or", 8'hFF, 1'b0, 1'b0);
      consume();
      issue(3'd6, 8'hFF, 8'h0F, 1'b0);
      check("nand ctl", {ainvert, binvert, op}, 4'b1101);
      check_rsp("nand", 8'hF0, 1'b0, 1'b0);
      consume();
      check("nand done", done_cnt, 0);
      check("keep sticky", ovf_sticky, 1);
      @(negedge clk);
      bus.cmd_valid = 1'b1; bus.cmd_opcode = 3'd2; bus.cmd_src1 = 8'h01; bus.cmd_src2 = 8'h01;
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      check("settle cmd_ready", bus.cmd_ready, 0);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check_idle("settle reset");
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("no rsp after reset", bus.rsp_valid, 0);
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
